// File: rtl/qpsk_modulator_if.sv
// rtl/qpsk_modulator_if.sv - byte stream handshake feeding the QPSK modulator
interface qpsk_modulator_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave  (input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/qpsk_modulator.sv
// rtl/qpsk_modulator.sv - framed byte to Gray-mapped QPSK symbols with preamble, tail and LO mixer
module qpsk_modulator #(
  parameter int SPS           = 8,
  parameter int AMP           = 16384,
  parameter int PREAMBLE_SYMS = 32,
  parameter int TAIL_SYMS     = 4
) (
  input  logic                clk,
  input  logic                reset,
  qpsk_modulator_if.slave     in_bus,
  input  logic signed [15:0]  lo_cos,
  input  logic signed [15:0]  lo_sin,
  output logic signed [15:0]  sym_i,
  output logic signed [15:0]  sym_q,
  output logic signed [31:0]  tx_out,
  output logic                busy,
  output logic                underrun
);
  localparam int SCW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int PCW = $clog2(PREAMBLE_SYMS + 1);
  localparam int TCW = $clog2(TAIL_SYMS + 1);
  localparam logic [SCW-1:0] SYM_LAST  = SCW'(SPS - 1);
  localparam logic [PCW-1:0] PRE_LAST  = PCW'(PREAMBLE_SYMS - 1);
  localparam logic [TCW-1:0] TAIL_LAST = TCW'(TAIL_SYMS - 1);
  localparam logic signed [15:0] LVL_P = 16'(AMP);
  localparam logic signed [15:0] LVL_N = 16'(-AMP);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, TAIL} state_t;

  state_t             state, state_next;
  logic [SCW-1:0]     sym_cnt, sym_cnt_next;
  logic [PCW-1:0]     pre_cnt, pre_cnt_next;
  logic [TCW-1:0]     tail_cnt, tail_cnt_next;
  logic [1:0]         dib_cnt, dib_cnt_next;
  logic [7:0]         byte_r, byte_next;
  logic               last_r, last_next;
  logic               gap_r, gap_next;
  logic signed [15:0] sym_i_next, sym_q_next;
  logic               underrun_next;
  logic               boundary;
  logic               ready;
  logic [1:0]         dibit;
  logic signed [31:0] prod_i, prod_q;
  logic signed [32:0] mix;

  function automatic logic signed [15:0] lvl(input logic b);
    return b ? LVL_N : LVL_P;
  endfunction

  assign boundary        = (sym_cnt == SYM_LAST);
  assign busy            = (state != IDLE);
  assign in_bus.in_ready = ready & reset;

  // dibit that follows the one currently on air
  always_comb begin
    dibit = 2'b00;
    case (dib_cnt)
      2'd0:    dibit = byte_r[5:4];
      2'd1:    dibit = byte_r[3:2];
      default: dibit = byte_r[1:0];
    endcase
  end

  always_comb begin
    state_next    = state;
    sym_cnt_next  = sym_cnt;
    pre_cnt_next  = pre_cnt;
    tail_cnt_next = tail_cnt;
    dib_cnt_next  = dib_cnt;
    byte_next     = byte_r;
    last_next     = last_r;
    gap_next      = gap_r;
    sym_i_next    = sym_i;
    sym_q_next    = sym_q;
    underrun_next = underrun;
    ready         = 1'b0;

    if (state != IDLE) begin
      sym_cnt_next = boundary ? '0 : sym_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        sym_i_next = '0;
        sym_q_next = '0;
        if (in_bus.in_valid) begin
          state_next    = PREAMBLE;
          pre_cnt_next  = '0;
          sym_i_next    = LVL_P;
          sym_q_next    = LVL_P;
          underrun_next = 1'b0;
        end
      end
      PREAMBLE: begin
        if (boundary) begin
          if (pre_cnt == PRE_LAST) begin
            ready = 1'b1;
          end else begin
            // even symbols carry dibit 00, odd symbols dibit 11
            pre_cnt_next = pre_cnt + 1'b1;
            sym_i_next   = pre_cnt[0] ? LVL_P : LVL_N;
            sym_q_next   = pre_cnt[0] ? LVL_P : LVL_N;
          end
        end
      end
      DATA: begin
        if (boundary) begin
          if (gap_r || (dib_cnt == 2'd3 && !last_r)) begin
            ready = 1'b1;
          end else if (dib_cnt == 2'd3) begin
            state_next    = TAIL;
            tail_cnt_next = '0;
            sym_i_next    = '0;
            sym_q_next    = '0;
          end else begin
            dib_cnt_next = dib_cnt + 1'b1;
            sym_i_next   = lvl(dibit[1]);
            sym_q_next   = lvl(dibit[0]);
          end
        end
      end
      TAIL: begin
        if (boundary) begin
          if (tail_cnt == TAIL_LAST) begin
            state_next = IDLE;
          end else begin
            tail_cnt_next = tail_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // byte boundary: take a new byte or fill with a zero symbol and retry
    if (ready) begin
      state_next   = DATA;
      dib_cnt_next = '0;
      if (in_bus.in_valid) begin
        byte_next  = in_bus.in_data;
        last_next  = in_bus.in_last;
        gap_next   = 1'b0;
        sym_i_next = lvl(in_bus.in_data[7]);
        sym_q_next = lvl(in_bus.in_data[6]);
      end else begin
        gap_next      = 1'b1;
        sym_i_next    = '0;
        sym_q_next    = '0;
        underrun_next = 1'b1;
      end
    end
  end

  assign prod_i = 32'(sym_i) * 32'(lo_cos);
  assign prod_q = 32'(sym_q) * 32'(lo_sin);
  assign mix    = 33'(prod_i) - 33'(prod_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      sym_cnt  <= '0;
      pre_cnt  <= '0;
      tail_cnt <= '0;
      dib_cnt  <= '0;
      byte_r   <= '0;
      last_r   <= 1'b0;
      gap_r    <= 1'b0;
      sym_i    <= '0;
      sym_q    <= '0;
      underrun <= 1'b0;
      tx_out   <= '0;
    end else begin
      state    <= state_next;
      sym_cnt  <= sym_cnt_next;
      pre_cnt  <= pre_cnt_next;
      tail_cnt <= tail_cnt_next;
      dib_cnt  <= dib_cnt_next;
      byte_r   <= byte_next;
      last_r   <= last_next;
      gap_r    <= gap_next;
      sym_i    <= sym_i_next;
      sym_q    <= sym_q_next;
      underrun <= underrun_next;
      tx_out   <= mix[32:1];
    end
  end
endmodule

// File: tb/tb_qpsk_modulator.sv
// tb/tb_qpsk_modulator.sv - table-driven bench for qpsk_modulator
module tb_qpsk_modulator;
  localparam int A = 16384;

  typedef struct {
    int frame;
    int cyc;
    int lc;
    int ls;
    bit busy;
    bit und;
    int si;
    int sq;
    int tx;
  } row_t;

  row_t rows[$];
  byte unsigned bytes_q[$];
  bit  lasts_q[$];
  int  offer_q[$];
  int  rdy_q[$];

  logic clk = 1'b0;
  logic reset;
  logic signed [15:0] lo_cos, lo_sin;
  logic signed [15:0] sym_i, sym_q;
  logic signed [31:0] tx_out;
  logic busy, underrun;
  int compared = 0;
  int mismatched = 0;

  qpsk_modulator_if bus();

  qpsk_modulator dut (
    .clk      (clk),
    .reset    (reset),
    .in_bus   (bus.slave),
    .lo_cos   (lo_cos),
    .lo_sin   (lo_sin),
    .sym_i    (sym_i),
    .sym_q    (sym_q),
    .tx_out   (tx_out),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void r(int f, int c, int lc, int ls, bit b, bit u, int si, int sq, int tx);
    row_t x;
    x = '{f, c, lc, ls, b, u, si, sq, tx};
    rows.push_back(x);
  endfunction

  task automatic run_frame(input int f, input int ncyc);
    int  bi;
    int  hs;
    bit  exp_rdy;
    bi = 0;
    hs = 0;
    lo_cos = '0;
    lo_sin = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (bi < bytes_q.size() && c >= offer_q[bi]) begin
        bus.in_valid = 1'b1;
        bus.in_data  = bytes_q[bi];
        bus.in_last  = lasts_q[bi];
      end else begin
        bus.in_valid = 1'b0;
      end
      foreach (rows[k]) begin
        if (rows[k].frame == f && rows[k].cyc == c) begin
          lo_cos = 16'(rows[k].lc);
          lo_sin = 16'(rows[k].ls);
          chk($sformatf("f%0d c%0d busy", f, c), busy, rows[k].busy);
          chk($sformatf("f%0d c%0d underrun", f, c), underrun, rows[k].und);
          chk($sformatf("f%0d c%0d sym_i", f, c), sym_i, rows[k].si);
          chk($sformatf("f%0d c%0d sym_q", f, c), sym_q, rows[k].sq);
          chk($sformatf("f%0d c%0d tx_out", f, c), tx_out, rows[k].tx);
        end
      end
      exp_rdy = 1'b0;
      foreach (rdy_q[k]) if (rdy_q[k] == c) exp_rdy = 1'b1;
      chk($sformatf("f%0d c%0d in_ready", f, c), bus.in_ready, exp_rdy);
      if (bus.in_valid && bus.in_ready) begin
        bi++;
        hs++;
      end
      step();
    end
    chk($sformatf("f%0d handshakes", f), hs, bytes_q.size());
  endtask

  initial begin
    // frame 1: preamble timing, mixer, mapping of 0xB4, tail
    r(1,   0, 0, 0, 0, 0,  0,  0, 0);
    r(1,   1, 0, 0, 1, 0,  A,  A, 0);
    r(1,   2, A, 0, 1, 0,  A,  A, 0);
    r(1,   3, 0, 0, 1, 0,  A,  A, 134217728);
    r(1,   4, 0, 0, 1, 0,  A,  A, 0);
    r(1,   8, 0, 0, 1, 0,  A,  A, 0);
    r(1,   9, 0, A, 1, 0, -A, -A, 0);
    r(1,  10, A, A, 1, 0, -A, -A, 134217728);
    r(1,  11,-A, A, 1, 0, -A, -A, 0);
    r(1,  12, 0, 0, 1, 0, -A, -A, 268435456);
    r(1,  13, 0, 0, 1, 0, -A, -A, 0);
    r(1,  16, 0, 0, 1, 0, -A, -A, 0);
    r(1,  17,-A, A, 1, 0,  A,  A, 0);
    r(1,  18, 0, 0, 1, 0,  A,  A, -268435456);
    r(1,  19, 0, 0, 1, 0,  A,  A, 0);
    r(1, 256, 0, 0, 1, 0, -A, -A, 0);
    r(1, 257, 0, 0, 1, 0, -A,  A, 0);
    r(1, 264, 0, 0, 1, 0, -A,  A, 0);
    r(1, 265, 0, 0, 1, 0, -A, -A, 0);
    r(1, 273, 0, 0, 1, 0,  A, -A, 0);
    r(1, 281, 0, 0, 1, 0,  A,  A, 0);
    r(1, 288, 0, 0, 1, 0,  A,  A, 0);
    r(1, 289, 0, 0, 1, 0,  0,  0, 0);
    r(1, 320, 0, 0, 1, 0,  0,  0, 0);
    r(1, 321, 0, 0, 0, 0,  0,  0, 0);
    // frame 2: 0x1B then underrun then 0x4E (last)
    r(2,   0, 0, 0, 0, 0,  0,  0, 0);
    r(2,   1, 0, 0, 1, 0,  A,  A, 0);
    r(2, 257, 0, 0, 1, 0,  A,  A, 0);
    r(2, 265, 0, 0, 1, 0,  A, -A, 0);
    r(2, 273, 0, 0, 1, 0, -A,  A, 0);
    r(2, 281, 0, 0, 1, 0, -A, -A, 0);
    r(2, 288, 0, 0, 1, 0, -A, -A, 0);
    r(2, 289, 0, 0, 1, 1,  0,  0, 0);
    r(2, 296, 0, 0, 1, 1,  0,  0, 0);
    r(2, 297, 0, 0, 1, 1,  A, -A, 0);
    r(2, 305, 0, 0, 1, 1,  A,  A, 0);
    r(2, 313, 0, 0, 1, 1, -A, -A, 0);
    r(2, 321, 0, 0, 1, 1, -A,  A, 0);
    r(2, 328, 0, 0, 1, 1, -A,  A, 0);
    r(2, 329, 0, 0, 1, 1,  0,  0, 0);
    r(2, 360, 0, 0, 1, 1,  0,  0, 0);
    r(2, 361, 0, 0, 0, 1,  0,  0, 0);
    // frame 3: underrun clears at frame start, then reset in DATA
    r(3,   0, 0, 0, 0, 1,  0,  0, 0);
    r(3,   1, 0, 0, 1, 0,  A,  A, 0);
    r(3, 257, 0, 0, 1, 0, -A, -A, 0);
    r(3, 260, 0, 0, 1, 0, -A, -A, 0);
    // frame 4: two back-to-back 3-byte frames
    r(4,   0, 0, 0, 0, 0,  0,  0, 0);
    r(4,   1, 0, 0, 1, 0,  A,  A, 0);
    r(4,   9, 0, 0, 1, 0, -A, -A, 0);
    r(4, 257, 0, 0, 1, 0,  A,  A, 0);
    r(4, 289, 0, 0, 1, 0,  A, -A, 0);
    r(4, 321, 0, 0, 1, 0, -A,  A, 0);
    r(4, 352, 0, 0, 1, 0, -A,  A, 0);
    r(4, 353, 0, 0, 1, 0,  0,  0, 0);
    r(4, 384, 0, 0, 1, 0,  0,  0, 0);
    r(4, 385, 0, 0, 0, 0,  0,  0, 0);
    r(4, 386, 0, 0, 1, 0,  A,  A, 0);
    r(4, 394, 0, 0, 1, 0, -A, -A, 0);
    r(4, 642, 0, 0, 1, 0,  A,  A, 0);
    r(4, 674, 0, 0, 1, 0, -A, -A, 0);
    r(4, 706, 0, 0, 1, 0,  A,  A, 0);
    r(4, 714, 0, 0, 1, 0, -A, -A, 0);
    r(4, 769, 0, 0, 1, 0,  0,  0, 0);
    r(4, 770, 0, 0, 0, 0,  0,  0, 0);

    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    lo_cos = 16'sd1000;
    lo_sin = -16'sd1000;
    repeat (3) step();
    chk("reset busy", busy, 0);
    chk("reset in_ready", bus.in_ready, 0);
    chk("reset sym_i", sym_i, 0);
    chk("reset sym_q", sym_q, 0);
    chk("reset tx_out", tx_out, 0);
    chk("reset underrun", underrun, 0);
    reset = 1'b1;
    step();

    bytes_q = '{8'hB4};
    lasts_q = '{1'b1};
    offer_q = '{0};
    rdy_q   = '{256};
    run_frame(1, 331);

    bytes_q = '{8'h1B, 8'h4E};
    lasts_q = '{1'b0, 1'b1};
    offer_q = '{0, 289};
    rdy_q   = '{256, 288, 296};
    run_frame(2, 370);

    bytes_q = '{8'hFF};
    lasts_q = '{1'b0};
    offer_q = '{0};
    rdy_q   = '{256};
    run_frame(3, 261);

    bus.in_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midreset busy", busy, 0);
    chk("midreset in_ready", bus.in_ready, 0);
    chk("midreset sym_i", sym_i, 0);
    chk("midreset sym_q", sym_q, 0);
    chk("midreset tx_out", tx_out, 0);
    chk("midreset underrun", underrun, 0);

    bytes_q = '{8'h00, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C};
    lasts_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    offer_q = '{0, 0, 0, 0, 0, 0};
    rdy_q   = '{256, 288, 320, 641, 673, 705};
    run_frame(4, 780);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/qpsk_modulator.md
Name: qpsk_modulator

Overview:
- Transmit-side counterpart of the Costas-loop carrier-recovery receiver.
- Accepts framed bytes over a valid/ready handshake and prepends a fixed preamble so the receiver loop can lock.
- Gray-maps bits two per symbol to QPSK I/Q levels, holds each symbol for SPS clocks, and mixes onto the carrier using LO samples from an external dds instance.
- Appends zero-level tail symbols after the last byte.

Parameters:
- SPS, 8, clocks per symbol (≥2).
- AMP, 16384, signed 16-bit symbol magnitude (≤16384).
- PREAMBLE_SYMS, 32, number of preamble symbols (≥1).
- TAIL_SYMS, 4, number of zero symbols after the last byte (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data valid; also requests frame start while IDLE.
- in_last  in  1  qualifies in_data as the final byte of the frame.
- in_ready  out  1  byte accepted on a cycle with in_valid & in_ready.
- lo_cos  in  16  signed carrier cosine from dds.
- lo_sin  in  16  signed carrier sine from dds.
- sym_i  out  16  signed baseband I level (registered).
- sym_q  out  16  signed baseband Q level (registered).
- tx_out  out  32  signed passband sample (registered).
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  sticky flag: data was not available at a byte boundary.

Behaviour:
- Reset, sampled on the clk edge while reset=0:
  - state=IDLE; sym_i, sym_q, tx_out = 0; in_ready=0, busy=0, underrun=0; all counters = 0.
  - Applies mid-frame too: the frame is abandoned and no tail is sent.
- Symbol counter:
  - sym_cnt runs 0..SPS-1 in PREAMBLE, DATA and TAIL.
  - The boundary cycle is sym_cnt==SPS-1; the next symbol's levels appear on sym_i/sym_q on the following cycle.
- Mapping, per dibit b1b0:
  - sym_i = b1 ? -AMP : +AMP.
  - sym_q = b0 ? -AMP : +AMP.
  - A "zero symbol" is sym_i = sym_q = 0.
- States:
  - IDLE: outputs zero. If in_valid=1, go to PREAMBLE next cycle. No byte is consumed (in_ready=0).
  - PREAMBLE: symbols alternate dibit 00, 11, 00, … starting with 00; PREAMBLE_SYMS symbols. At the boundary of the last preamble symbol, enter DATA.
  - DATA: each byte is sent MSB first as dibits [7:6], [5:4], [3:2], [1:0].
  - TAIL: TAIL_SYMS zero symbols, then IDLE.
- in_ready (combinational):
  - Asserted only on the boundary cycle of the final preamble symbol.
  - Also on the boundary cycle of the [1:0] dibit of a non-last byte.
  - Also on the boundary of an underrun zero symbol.
  - Deasserted on all other cycles.
- Byte capture:
  - At a ready boundary, in_valid=1 latches in_data and in_last; the next symbol is dibit [7:6].
  - At a ready boundary, in_valid=0 sends a zero symbol in DATA, sets underrun, and retries at the next boundary.
- Last byte: after the [1:0] dibit of a byte captured with in_last=1, enter TAIL; in_ready stays 0.
- underrun: sticky; cleared only by reset or by the IDLE→PREAMBLE transition.
- Mixer, 1 cycle latency: tx_out <= (sym_i*lo_cos − sym_q*lo_sin) >>> 1.
  - Full 33-bit signed difference, arithmetic shift right by 1, truncated to 32 bits.
  - No saturation is needed given AMP ≤ 16384.
- Back-to-back frames: at least one IDLE cycle separates frames.
- Frame length is SPS·(PREAMBLE_SYMS + 4·bytes + underrun_syms + TAIL_SYMS) cycles.

Test Plan:
- Preamble timing (SPS=8, PREAMBLE_SYMS=32): in_valid=1 in IDLE at cycle 0.
  - busy=1 from cycle 1; sym_i=sym_q=+16384 for cycles 1–8, −16384 for cycles 9–16.
  - in_ready=1 only at cycle 256.
- Mapping: single byte 0xB4, in_last=1, valid at the ready boundary.
  - Dibits 10, 11, 01, 00 give (I,Q) = (−A,+A), (−A,−A), (+A,−A), (+A,+A), 8 cycles each.
  - Then 4 zero symbols (32 cycles); busy falls after the tail.
- Underrun: in_valid low at the second-byte boundary.
  - One zero symbol; underrun=1; in_ready pulses again 8 cycles later; byte accepted then.
  - underrun stays 1 until the next frame start.
- Mixer: force lo_cos=16384, lo_sin=0 with sym_i=+16384 → tx_out=134217728 one cycle later.
  - With lo_cos=0, lo_sin=16384, sym_q=−16384 → tx_out=134217728.
- Reset mid-DATA: reset=0 for one cycle.
  - Next cycle: IDLE, all outputs 0, in_ready=0; a new frame restarts with the full preamble.
- Back-to-back: two 3-byte frames with in_valid held high.
  - Exactly one IDLE cycle between TAIL end and the next PREAMBLE; 6 byte handshakes total, none lost or duplicated.
